// File: rtl/request_encoder_if.sv
// Handshake bundle for request_encoder.
//   Request side : req_valid, req_ready, req_vec[N-1:0]
//   Code side    : code_valid, code_ready, code[AW-1:0], code_last
//   Status       : busy
// Modports:
//   master - upstream/downstream environment (drives req_valid, req_vec, code_ready)
//   slave  - the encoder itself
// N and AW must match the parameters of the request_encoder instance.
interface request_encoder_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = 2
);
  logic          req_valid;
  logic          req_ready;
  logic [N-1:0]  req_vec;
  logic          code_valid;
  logic          code_ready;
  logic [AW-1:0] code;
  logic          code_last;
  logic          busy;

  modport master (
    output req_valid,
    output req_vec,
    output code_ready,
    input  req_ready,
    input  code_valid,
    input  code,
    input  code_last,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_vec,
    input  code_ready,
    output req_ready,
    output code_valid,
    output code,
    output code_last,
    output busy
  );
endinterface

// File: rtl/request_encoder.sv
// request_encoder: serialises a multi-hot request vector into binary codes.
// A vector is taken over the req handshake; each set bit is then emitted as one code over the
// code handshake, with code_last marking the final code of the vector. No overlap between vectors.
//
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - request_encoder_if.slave (req_valid/req_ready/req_vec, code_valid/code_ready/
//             code/code_last, busy)
//
// Configuration macro REQUEST_ENCODER_RR_EN:
//   undefined - fixed priority, lowest pending index wins; ptr stays at N-1
//   defined   - rotating priority, search starts at ptr+1, ptr follows each transferred code
module request_encoder #(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = 2
) (
  input logic              clk,
  input logic              reset_n,
  request_encoder_if.slave bus
);

  if (AW != $clog2(N)) begin : g_bad_aw
    $error("request_encoder: AW must equal log2(N)");
  end
  if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $error("request_encoder: N must be a power of two >= 2");
  end

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] code_q, code_d;
  logic          last_q, last_d;

  // Search starts at ptr+1 (mod N). With ptr pinned at N-1 this is plain lowest-index-first,
  // so one search routine serves both priority modes.
  function automatic logic [AW-1:0] pick_code(input logic [N-1:0]  vec,
                                              input logic [AW-1:0] ptr);
    logic [AW-1:0] idx;
    logic          found;
    pick_code = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = ptr + AW'(1) + AW'(k);
      if (!found && vec[idx]) begin
        pick_code = idx;
        found     = 1'b1;
      end
    end
  endfunction

  function automatic logic single_bit(input logic [N-1:0] vec);
    return (vec != '0) && ((vec & (vec - N'(1))) == '0);
  endfunction

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ptr_d     = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          // An all-zero vector is consumed without leaving idle.
          pending_d = bus.req_vec;
          if (bus.req_vec != '0) state_d = StSend;
        end
      end
      StSend: begin
        if (bus.code_ready) begin
          pending_d = pending_q & ~(N'(1) << code_q);
`ifdef REQUEST_ENCODER_RR_EN
          ptr_d = code_q;
`endif
          if (last_q) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // code/code_last are precomputed from next-state so the outputs come straight from flops.
    code_d = pick_code(pending_d, ptr_d);
    last_d = single_bit(pending_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      ptr_q     <= AW'(N - 1);
      code_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      code_q    <= code_d;
      last_q    <= last_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.code_valid = (state_q == StSend);
  assign bus.busy       = (state_q == StSend);
  assign bus.code       = code_q;
  assign bus.code_last  = last_q;

  // A stalled code must not change under backpressure.
  a_hold_stable : assert property (@(posedge clk) disable iff (!reset_n)
    bus.code_valid && !bus.code_ready |=>
      bus.code_valid && $stable(bus.code) && $stable(bus.code_last));

  // Every presented code refers to a bit that is still pending.
  a_code_pending : assert property (@(posedge clk) disable iff (!reset_n)
    bus.code_valid |-> pending_q[code_q]);

endmodule

// File: tb/tb_request_encoder.sv
module tb_request_encoder;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 2;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  request_encoder_if #(.N(N), .AW(AW)) bus ();

  request_encoder #(.N(N), .AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid  = 1'b0;
    bus.req_vec    = '0;
    bus.code_ready = 1'b1;
    reset_n        = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // {code_valid, code, code_last, busy, req_ready}
  task automatic test_reset();
    logic [5:0] got;
    bus.req_valid  = 1'b0;
    bus.req_vec    = '0;
    bus.code_ready = 1'b0;
    reset_n        = 1'b0;
    #3;
    got = {bus.code_valid, bus.code, bus.code_last, bus.busy, bus.req_ready};
    checks++;
    if (got !== 6'b0_00_0_0_1) begin
      errors++;
      $display("FAIL reset_state: got %b want 000001", got);
    end
    step();
    reset_n = 1'b1;
    step();
    got = {bus.code_valid, bus.code, bus.code_last, bus.busy, bus.req_ready};
    checks++;
    if (got !== 6'b0_00_0_0_1) begin
      errors++;
      $display("FAIL reset_release_idle: got %b want 000001", got);
    end
  endtask

  task automatic test_fixed_basic();
    logic [1:0] exp_code [2] = '{2'd1, 2'd3};
    logic [5:0] got, want;
    do_reset();
    bus.req_vec   = 4'b1010;
    bus.req_valid = 1'b1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_req_ready: got %b want 1", bus.req_ready);
    end
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      got  = {bus.code_valid, bus.code, bus.code_last, bus.busy, bus.req_ready};
      want = {1'b1, exp_code[i], (i == 1), 1'b1, 1'b0};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL basic_code%0d: got %b want %b", i, got, want);
      end
      step();
    end
    got = {bus.code_valid, bus.code, bus.code_last, bus.busy, bus.req_ready};
    checks++;
    if (got !== 6'b0_00_0_0_1) begin
      errors++;
      $display("FAIL basic_back_idle: got %b want 000001", got);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] got, want;
    do_reset();
    bus.code_ready = 1'b0;
    bus.req_vec    = 4'b0111;
    bus.req_valid  = 1'b1;
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      got = {bus.code_valid, bus.code, bus.code_last};
      checks++;
      if (got !== 4'b1_00_0) begin
        errors++;
        $display("FAIL bp_hold%0d: got %b want 1000", i, got);
      end
      step();
    end
    bus.code_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      got  = {bus.code_valid, bus.code, bus.code_last};
      want = {1'b1, 2'(i), (i == 2)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL bp_code%0d: got %b want %b", i, got, want);
      end
      step();
    end
    checks++;
    if ({bus.code_valid, bus.req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_back_idle: got %b want 01", {bus.code_valid, bus.req_ready});
    end
  endtask

  task automatic test_zero_vec();
    logic [2:0] got;
    do_reset();
    bus.req_vec   = 4'b0000;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      got = {bus.code_valid, bus.busy, bus.req_ready};
      checks++;
      if (got !== 3'b001) begin
        errors++;
        $display("FAIL zero_vec%0d: got %b want 001", i, got);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_send();
    logic [5:0] got;
    do_reset();
    bus.req_vec   = 4'b1100;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    got = {bus.code_valid, bus.code, bus.code_last, bus.busy, bus.req_ready};
    checks++;
    if (got !== 6'b1_10_0_1_0) begin
      errors++;
      $display("FAIL rst_mid_first: got %b want 110010", got);
    end
    step();
    got = {bus.code_valid, bus.code, bus.code_last, bus.busy, bus.req_ready};
    checks++;
    if (got !== 6'b1_11_1_1_0) begin
      errors++;
      $display("FAIL rst_mid_second: got %b want 111110", got);
    end
    #2;
    reset_n = 1'b0;
    #1;
    got = {bus.code_valid, bus.code, bus.code_last, bus.busy, bus.req_ready};
    checks++;
    if (got !== 6'b0_00_0_0_1) begin
      errors++;
      $display("FAIL rst_mid_async: got %b want 000001", got);
    end
    #2;
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.code_valid, bus.req_ready} !== 2'b01) begin
        errors++;
        $display("FAIL rst_mid_no_stale%0d: got %b want 01", i,
                 {bus.code_valid, bus.req_ready});
      end
      step();
    end
  endtask

  task automatic test_hold_during_send();
    logic [4:0] got;
    do_reset();
    bus.req_vec   = 4'b0011;
    bus.req_valid = 1'b1;
    step();
    bus.req_vec = 4'b1000;  // new vector waits with req_valid high
    got = {bus.code_valid, bus.code, bus.code_last, bus.req_ready};
    checks++;
    if (got !== 5'b1_00_0_0) begin
      errors++;
      $display("FAIL hold_code0: got %b want 10000", got);
    end
    step();
    got = {bus.code_valid, bus.code, bus.code_last, bus.req_ready};
    checks++;
    if (got !== 5'b1_01_1_0) begin
      errors++;
      $display("FAIL hold_code1: got %b want 10110", got);
    end
    step();
    checks++;
    if ({bus.code_valid, bus.req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL hold_idle: got %b want 01", {bus.code_valid, bus.req_ready});
    end
    step();
    bus.req_valid = 1'b0;
    got = {bus.code_valid, bus.code, bus.code_last, bus.req_ready};
    checks++;
    if (got !== 5'b1_11_1_0) begin
      errors++;
      $display("FAIL hold_new_code: got %b want 11110", got);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({bus.code_valid, bus.req_ready} !== 2'b01) begin
        errors++;
        $display("FAIL hold_no_dup%0d: got %b want 01", i, {bus.code_valid, bus.req_ready});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] vecs [4] = '{4'b1111, 4'b1111, 4'b0010, 4'b0101};
    int         cnts [4] = '{4, 4, 1, 2};
`ifdef REQUEST_ENCODER_RR_EN
    logic [1:0] exp_code [11] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 2, 0};
`else
    logic [1:0] exp_code [11] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 0, 2};
`endif
    logic [3:0] got, want;
    int         p = 0;
    do_reset();
    for (int v = 0; v < 4; v++) begin
      checks++;
      if (bus.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_v%0d: got %b want 1", v, bus.req_ready);
      end
      bus.req_vec   = vecs[v];
      bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
      for (int j = 0; j < cnts[v]; j++) begin
        got  = {bus.code_valid, bus.code, bus.code_last};
        want = {1'b1, exp_code[p], (j == cnts[v] - 1)};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL b2b_v%0d_c%0d: got %b want %b", v, j, got, want);
        end
        p++;
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_basic();
    test_backpressure();
    test_zero_vec();
    test_reset_mid_send();
    test_hold_during_send();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
